bz_link_rx_packer: RTL and testbench
====================================

Name: bz_link_rx_packer

Overview:
Receive side of the inter-board flit link. It takes header-plus-data flits from the neighbouring board's top link, already in the core clock domain, with a valid/ready handshake. It reassembles each packet into one wide word and steers it to one of NUM_CH downstream consumers, chosen by route. It is the parametrised successor of the fixed 11-bit header/3-data-flit link logic, and adds:
- variable packet length;
- length-error drop;
- inter-flit timeout;
- multi-channel output.

Parameters:
FLIT_W, 11, link flit width in bits.
ROUTE_W, 6, route field width; occupies header bits [FLIT_W-1 -: ROUTE_W].
LEN_W, 3, data-flit count field width; occupies header bits [LEN_W-1:0].
MAX_FLITS, 4, maximum data flits per packet. PAYLOAD_W = FLIT_W*MAX_FLITS is derived.
NUM_CH, 2, number of output channels; must be a power of 2.
TIMEOUT, 255, idle cycles allowed between flits of one packet before the packet is aborted.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous, active-low reset
in_flit  in  FLIT_W  flit from link
in_valid  in  1  in_flit valid
in_ready  out  1  block accepts in_flit this cycle
out_route  out  ROUTE_W  route of emitted packet
out_len  out  LEN_W  data-flit count of emitted packet
out_payload  out  PAYLOAD_W  packed data flits
out_valid  out  NUM_CH  one-hot per-channel valid
out_ready  in  NUM_CH  per-channel ready
err_len_cnt  out  8  saturating count of packets dropped for len > MAX_FLITS
err_timeout_cnt  out  8  saturating count of packets aborted by timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE;
  - out_valid=0, out_route/out_len/out_payload=0;
  - both error counters=0;
  - in_ready=0 while reset_n is low, rising in the first IDLE cycle after release.
  - Reset mid-packet discards partial data and emits nothing.
- A flit transfers on a clk edge with in_valid & in_ready.
- Header decode:
  - route = in_flit[FLIT_W-1 -: ROUTE_W], len = in_flit[LEN_W-1:0];
  - bits between the two fields are reserved and ignored;
  - channel = route[$clog2(NUM_CH)-1:0].
- IDLE: in_ready=1. On header accept:
  - len==0 -> EMIT, with payload 0.
  - 1<=len<=MAX_FLITS -> DATA; clear payload register and flit index.
  - len>MAX_FLITS -> DROP; remaining = len.
- DATA: in_ready=1.
  - Flit k (0-based) is written to payload[k*FLIT_W +: FLIT_W]; unused upper flits stay 0.
  - After flit len-1 is accepted -> EMIT.
- DROP: in_ready=1.
  - Consumes len flits, discarding them.
  - After the last flit: err_len_cnt++ (saturating at 255) -> IDLE.
- Timeout (DATA and DROP):
  - The idle counter resets on every accepted flit and increments otherwise.
  - When it reaches TIMEOUT: err_timeout_cnt++ (saturating), partial data discarded, -> IDLE.
  - If timeout and a flit accept coincide, the flit wins.
- EMIT: in_ready=0.
  - out_valid[channel]=1; all other bits are 0.
  - out_route, out_len and out_payload are registered and held stable while out_valid & ~out_ready[channel].
  - out_ready on non-selected channels is ignored.
  - On handshake: out_valid=0 next cycle -> IDLE.
- Latency:
  - Last data flit accepted at edge N -> out_valid high after edge N.
  - A len==0 header accepted at edge N -> out_valid high after edge N.
  - Handshake at edge M -> IDLE and in_ready=1 after edge M; one bubble per packet.
- The len field is interpreted as unsigned; LEN_W may encode values above MAX_FLITS, which is the drop case.

Decomposition:
- Package bz_link_pkg holds:
  - state enum {IDLE, DATA, DROP, EMIT};
  - header field position functions or localparams derived from FLIT_W, ROUTE_W and LEN_W;
  - ERR_CNT_W=8.
- One sub-module, bz_sat_counter (width param, inc, async active-low clear), instantiated twice for the error counters.

Test Plan:
1. Header 11'h063 (route 3, len 3), then flits 11'h001, 11'h007, 11'h01F, with out_ready=2'b11 -> out_valid=2'b10 one cycle after the last flit; out_route=3, out_len=3, out_payload=44'h0000_7C03801.
2. Same packet with out_ready[1]=0 for 10 cycles -> in_ready=0 and outputs stable for all 10 cycles; out_valid drops one cycle after out_ready[1]=1; in_ready=1 the following cycle.
3. Header 11'h045 (route 2, len 5), then 5 flits -> no out_valid, err_len_cnt=1; a subsequent packet per test 1 emits normally.
4. TIMEOUT=16: header 11'h063, one flit, then in_valid=0 for 16 cycles -> err_timeout_cnt=1, busy=0, nothing emitted; the next header decodes as a fresh packet.
5. Header 11'h080 (route 4, len 0) -> out_valid=2'b01 one cycle later, out_len=0, out_payload=0.
6. Assert reset_n low mid-DATA (after 1 of 3 flits) -> out_valid=0 and in_ready=0 immediately, counters=0; after release, in_ready=1 and test 1 passes.

Source files
------------

// File: rtl/bz_link_pkg.sv
// ---------------------------------------------------------------------------
// bz_link_pkg
// Shared definitions for the inter-board link receive path.
//   state_e    : packer FSM states (IDLE, DATA, DROP, EMIT)
//   ERR_CNT_W  : width of the saturating error counters
//   route_lsb  : bit position of the route field LSB in a header flit
//   ch_width   : channel-select width for a given number of channels
// ---------------------------------------------------------------------------
package bz_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_DROP = 2'd2,
      ST_EMIT = 2'd3
   } state_e;

   localparam int ERR_CNT_W = 8;

   // Route occupies the top ROUTE_W bits of the header flit.
   function automatic int route_lsb(input int flit_w, input int route_w);
      return flit_w - route_w;
   endfunction

   // At least one bit of channel select, even for a single channel.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/bz_sat_counter.sv
// ---------------------------------------------------------------------------
// bz_sat_counter
// Saturating up-counter; sticks at all-ones.
//   clk     : clock
//   clear_n : asynchronous active-low clear
//   inc     : count enable (one increment per cycle)
//   count   : current count value
// ---------------------------------------------------------------------------
module bz_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_r;

   // Count register: increments on inc until it reaches all-ones.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count_r <= '0;
      end else if (inc && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/bz_link_rx_packer.sv
// ---------------------------------------------------------------------------
// bz_link_rx_packer
// Receive side of the inter-board flit link. Collects a header flit plus
// len data flits into one wide payload and presents it on the output
// channel selected by the low bits of the route field.
//   clk, reset_n     : core clock, asynchronous active-low reset
//   in_flit/in_valid : flit stream from the link
//   in_ready         : flit accepted on this edge when in_valid & in_ready
//   out_route/len    : route and data-flit count of the emitted packet
//   out_payload      : data flits, flit k at [k*FLIT_W +: FLIT_W]
//   out_valid        : one-hot valid on the selected channel
//   out_ready        : per-channel ready (only the selected bit matters)
//   err_len_cnt      : packets dropped because len > MAX_FLITS
//   err_timeout_cnt  : packets aborted by the inter-flit timeout
//   busy             : packer not idle
// ---------------------------------------------------------------------------
module bz_link_rx_packer
   import bz_link_pkg::*;
#(
   parameter int FLIT_W    = 11,
   parameter int ROUTE_W   = 6,
   parameter int LEN_W     = 3,
   parameter int MAX_FLITS = 4,
   parameter int NUM_CH    = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [FLIT_W-1:0]             in_flit,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [ROUTE_W-1:0]            out_route,
   output logic [LEN_W-1:0]              out_len,
   output logic [FLIT_W*MAX_FLITS-1:0]   out_payload,
   output logic [NUM_CH-1:0]             out_valid,
   input  logic [NUM_CH-1:0]             out_ready,
   output logic [ERR_CNT_W-1:0]          err_len_cnt,
   output logic [ERR_CNT_W-1:0]          err_timeout_cnt,
   output logic                          busy
);

   localparam int PAYLOAD_W = FLIT_W * MAX_FLITS;
   localparam int ROUTE_LSB = route_lsb(FLIT_W, ROUTE_W);
   localparam int CH_W      = ch_width(NUM_CH);
   localparam int TO_W      = $clog2(TIMEOUT + 1);

   localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   // Abort when the idle count would reach TIMEOUT on this edge.
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   // Registered state
   state_e                 state_r;
   logic [LEN_W-1:0]       rem_r;
   logic [LEN_W-1:0]       idx_r;
   logic [TO_W-1:0]        idle_r;
   logic [PAYLOAD_W-1:0]   payload_r;
   logic [ROUTE_W-1:0]     route_r;
   logic [LEN_W-1:0]       len_r;
   logic [CH_W-1:0]        ch_r;
   logic [NUM_CH-1:0]      out_valid_r;
   logic                   in_ready_r;
   logic                   busy_r;

   // Next-state values
   state_e                 state_nxt_s;
   logic [LEN_W-1:0]       rem_nxt_s;
   logic [LEN_W-1:0]       idx_nxt_s;
   logic [TO_W-1:0]        idle_nxt_s;
   logic [PAYLOAD_W-1:0]   payload_nxt_s;
   logic [ROUTE_W-1:0]     route_nxt_s;
   logic [LEN_W-1:0]       len_nxt_s;
   logic [CH_W-1:0]        ch_nxt_s;
   logic [NUM_CH-1:0]      out_valid_nxt_s;

   // Header decode and handshakes
   logic                   accept_s;
   logic [ROUTE_W-1:0]     hdr_route_s;
   logic [LEN_W-1:0]       hdr_len_s;
   logic [CH_W-1:0]        hdr_ch_s;
   logic                   len_err_inc_s;
   logic                   timeout_inc_s;

   assign accept_s    = in_valid & in_ready_r;
   assign hdr_route_s = in_flit[ROUTE_LSB +: ROUTE_W];
   assign hdr_len_s   = in_flit[LEN_W-1:0];
   assign hdr_ch_s    = (NUM_CH > 1) ? hdr_route_s[CH_W-1:0] : '0;

   // Packet FSM: header decode, data collection, drop and timeout handling.
   always_comb begin
      state_nxt_s   = state_r;
      rem_nxt_s     = rem_r;
      idx_nxt_s     = idx_r;
      idle_nxt_s    = idle_r;
      payload_nxt_s = payload_r;
      route_nxt_s   = route_r;
      len_nxt_s     = len_r;
      ch_nxt_s      = ch_r;
      len_err_inc_s = 1'b0;
      timeout_inc_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               route_nxt_s   = hdr_route_s;
               len_nxt_s     = hdr_len_s;
               ch_nxt_s      = hdr_ch_s;
               payload_nxt_s = '0;
               idx_nxt_s     = LEN_ZERO;
               idle_nxt_s    = '0;
               rem_nxt_s     = hdr_len_s;
               if (hdr_len_s == LEN_ZERO) begin
                  state_nxt_s = ST_EMIT;
               end else if (int'(hdr_len_s) <= MAX_FLITS) begin
                  state_nxt_s = ST_DATA;
               end else begin
                  state_nxt_s = ST_DROP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (accept_s) begin
               // Only the slot addressed by idx_r takes the flit.
               for (int k = 0; k < MAX_FLITS; k++) begin
                  payload_nxt_s[k*FLIT_W +: FLIT_W] =
                     (idx_r == LEN_W'(k)) ? in_flit : payload_r[k*FLIT_W +: FLIT_W];
               end
               idx_nxt_s  = idx_r + LEN_ONE;
               rem_nxt_s  = rem_r - LEN_ONE;
               idle_nxt_s = '0;
               if (rem_r == LEN_ONE) begin
                  state_nxt_s = ST_EMIT;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else if (idle_r == TO_LAST) begin
               timeout_inc_s = 1'b1;
               payload_nxt_s = '0;
               rem_nxt_s     = LEN_ZERO;
               idle_nxt_s    = '0;
               state_nxt_s   = ST_IDLE;
            end else begin
               idle_nxt_s = idle_r + TO_ONE;
            end
         end

         ST_DROP: begin
            if (accept_s) begin
               rem_nxt_s  = rem_r - LEN_ONE;
               idle_nxt_s = '0;
               if (rem_r == LEN_ONE) begin
                  len_err_inc_s = 1'b1;
                  state_nxt_s   = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DROP;
               end
            end else if (idle_r == TO_LAST) begin
               timeout_inc_s = 1'b1;
               rem_nxt_s     = LEN_ZERO;
               idle_nxt_s    = '0;
               state_nxt_s   = ST_IDLE;
            end else begin
               idle_nxt_s = idle_r + TO_ONE;
            end
         end

         ST_EMIT: begin
            // Only the selected channel's ready completes the handshake.
            if (out_ready[ch_r]) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // One-hot valid for the channel that will be presented next cycle.
   always_comb begin
      out_valid_nxt_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         out_valid_nxt_s[k] = (state_nxt_s == ST_EMIT) && (ch_nxt_s == CH_W'(k));
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         rem_r       <= LEN_ZERO;
         idx_r       <= LEN_ZERO;
         idle_r      <= '0;
         payload_r   <= '0;
         route_r     <= '0;
         len_r       <= LEN_ZERO;
         ch_r        <= '0;
         out_valid_r <= '0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         rem_r       <= rem_nxt_s;
         idx_r       <= idx_nxt_s;
         idle_r      <= idle_nxt_s;
         payload_r   <= payload_nxt_s;
         route_r     <= route_nxt_s;
         len_r       <= len_nxt_s;
         ch_r        <= ch_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         in_ready_r  <= (state_nxt_s != ST_EMIT);
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign out_valid   = out_valid_r;
   assign out_route   = route_r;
   assign out_len     = len_r;
   assign out_payload = payload_r;

   bz_sat_counter #(
      .WIDTH   (ERR_CNT_W)
   ) u_err_len_cnt (
      .clk     (clk),
      .clear_n (reset_n),
      .inc     (len_err_inc_s),
      .count   (err_len_cnt)
   );

   bz_sat_counter #(
      .WIDTH   (ERR_CNT_W)
   ) u_err_timeout_cnt (
      .clk     (clk),
      .clear_n (reset_n),
      .inc     (timeout_inc_s),
      .count   (err_timeout_cnt)
   );

endmodule

// File: tb/tb_bz_link_rx_packer.sv
// ---------------------------------------------------------------------------
// tb_bz_link_rx_packer
// Directed packets with literal expectations, then randomized flit traffic,
// all compared every cycle against a packet-level model.
// ---------------------------------------------------------------------------
module tb_bz_link_rx_packer;

   localparam int FLIT_W    = 11;
   localparam int ROUTE_W   = 6;
   localparam int LEN_W     = 3;
   localparam int MAX_FLITS = 4;
   localparam int NUM_CH    = 2;
   localparam int TIMEOUT   = 16;
   localparam int PW        = FLIT_W * MAX_FLITS;

   logic               clk = 1'b0;
   logic               reset_n = 1'b1;
   logic [FLIT_W-1:0]  in_flit = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [ROUTE_W-1:0] out_route;
   logic [LEN_W-1:0]   out_len;
   logic [PW-1:0]      out_payload;
   logic [NUM_CH-1:0]  out_valid;
   logic [NUM_CH-1:0]  out_ready = 2'b11;
   logic [7:0]         err_len_cnt;
   logic [7:0]         err_timeout_cnt;
   logic               busy;

   int n_tests = 0;
   int n_fail  = 0;

   bz_link_rx_packer #(
      .FLIT_W(FLIT_W), .ROUTE_W(ROUTE_W), .LEN_W(LEN_W),
      .MAX_FLITS(MAX_FLITS), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .out_route(out_route), .out_len(out_len),
      .out_payload(out_payload), .out_valid(out_valid), .out_ready(out_ready),
      .err_len_cnt(err_len_cnt), .err_timeout_cnt(err_timeout_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- packet-level reference model ----------------
   bit                m_rdy   = 1'b0;   // model's view of in_ready
   bit                m_have  = 1'b0;   // a packet is being presented
   int                m_rem   = 0;      // flits still expected for current packet
   bit                m_drop  = 1'b0;
   int                m_idle  = 0;
   int                m_route = 0;
   int                m_len   = 0;
   int                m_ch    = 0;
   logic [PW-1:0]     m_pay   = '0;
   logic [FLIT_W-1:0] m_flits[$];
   int                m_elen  = 0;
   int                m_eto   = 0;
   int                emitted = 0;

   task automatic model_reset();
      m_rdy = 1'b0; m_have = 1'b0; m_rem = 0; m_drop = 1'b0; m_idle = 0;
      m_flits.delete(); m_elen = 0; m_eto = 0;
   endtask

   task automatic model_step();
      bit acc;
      acc = in_valid && m_rdy;
      if (m_have) begin
         if (out_ready[m_ch]) begin
            m_have = 1'b0;
            emitted++;
         end
      end else if (m_rem == 0) begin
         if (acc) begin
            m_route = int'(in_flit[FLIT_W-1 -: ROUTE_W]);
            m_len   = int'(in_flit[LEN_W-1:0]);
            m_ch    = m_route % NUM_CH;
            m_flits.delete();
            m_idle  = 0;
            if (m_len == 0) begin
               m_pay  = '0;
               m_have = 1'b1;
            end else begin
               m_rem  = m_len;
               m_drop = (m_len > MAX_FLITS);
            end
         end
      end else begin
         if (acc) begin
            if (!m_drop) m_flits.push_back(in_flit);
            m_rem--;
            m_idle = 0;
            if (m_rem == 0) begin
               if (m_drop) begin
                  if (m_elen < 255) m_elen++;
               end else begin
                  m_pay = '0;
                  foreach (m_flits[k]) m_pay = m_pay | (PW'(m_flits[k]) << (k * FLIT_W));
                  m_have = 1'b1;
               end
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               if (m_eto < 255) m_eto++;
               m_rem = 0;
               m_flits.delete();
            end
         end
      end
      m_rdy = !m_have;
   endtask

   always @(negedge reset_n) model_reset();
   always @(posedge clk) if (reset_n) model_step();

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [NUM_CH-1:0] exp_ov;
      exp_ov = '0;
      if (m_have) exp_ov[m_ch] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("busy", 64'(busy), 64'(m_have || (m_rem > 0)));
      check("err_len_cnt", 64'(err_len_cnt), 64'(m_elen));
      check("err_timeout_cnt", 64'(err_timeout_cnt), 64'(m_eto));
      if (m_have) begin
         check("out_route", 64'(out_route), 64'(m_route));
         check("out_len", 64'(out_len), 64'(m_len));
         check("out_payload", 64'(out_payload), 64'(m_pay));
      end
   end

   // ---------------- stimulus ----------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_flit(input logic [FLIT_W-1:0] f);
      int guard;
      guard = 0;
      in_flit  = f;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_wait: in_ready stuck 0 for flit %0h", f);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_test1_packet();
      send_flit(11'h063);
      send_flit(11'h001);
      send_flit(11'h007);
      send_flit(11'h01F);
   endtask

   task automatic check_test1_out(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'h2);
      check({tag, "_route"}, 64'(out_route), 64'd3);
      check({tag, "_len"}, 64'(out_len), 64'd3);
      check({tag, "_payload"}, 64'(out_payload), 64'h0000_7C03801);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_payload", 64'(out_payload), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Test 1: basic 3-flit packet on channel 1
      out_ready = 2'b11;
      send_test1_packet();
      check_test1_out("t1");
      @(negedge clk);
      check("t1_valid_drop", 64'(out_valid), 64'd0);
      check("t1_in_ready", 64'(in_ready), 64'd1);

      // Test 2: back-pressure on the selected channel, other ready ignored
      out_ready = 2'b01;
      send_test1_packet();
      for (int i = 0; i < 10; i++) begin
         check_test1_out("t2_hold");
         check("t2_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 2'b11;
      @(negedge clk);
      check("t2_valid_drop", 64'(out_valid), 64'd0);
      check("t2_in_ready_back", 64'(in_ready), 64'd1);

      // Test 3: len 5 exceeds MAX_FLITS -> dropped
      send_flit(11'h045);
      for (int i = 0; i < 5; i++) send_flit(11'(i + 9));
      check("t3_err_len", 64'(err_len_cnt), 64'd1);
      check("t3_no_valid", 64'(out_valid), 64'd0);
      send_test1_packet();
      check_test1_out("t3_next");
      @(negedge clk);

      // Test 4: inter-flit timeout
      send_flit(11'h063);
      send_flit(11'h001);
      repeat (15) @(negedge clk);
      check("t4_busy_before", 64'(busy), 64'd1);
      check("t4_err_before", 64'(err_timeout_cnt), 64'd0);
      @(negedge clk);
      check("t4_err_to", 64'(err_timeout_cnt), 64'd1);
      check("t4_busy", 64'(busy), 64'd0);
      send_test1_packet();
      check_test1_out("t4_next");
      @(negedge clk);

      // Test 5: zero-length packet on channel 0
      send_flit(11'h080);
      check("t5_valid", 64'(out_valid), 64'h1);
      check("t5_len", 64'(out_len), 64'd0);
      check("t5_payload", 64'(out_payload), 64'd0);
      check("t5_route", 64'(out_route), 64'd4);
      @(negedge clk);

      // Test 6: reset in the middle of a packet
      send_flit(11'h063);
      send_flit(11'h001);
      #2 reset_n = 1'b0;
      #1;
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_in_ready", 64'(in_ready), 64'd0);
      check("t6_err_len", 64'(err_len_cnt), 64'd0);
      check("t6_err_to", 64'(err_timeout_cnt), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_ready_after", 64'(in_ready), 64'd1);
      send_test1_packet();
      check_test1_out("t6_next");
      @(negedge clk);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            in_valid  = 1'b0;
            out_ready = 2'b11;
            repeat (20) @(negedge clk);
         end
         in_valid  = ($urandom_range(0, 99) < 70);
         in_flit   = FLIT_W'($urandom);
         out_ready = NUM_CH'($urandom_range(0, 3));
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 2'b11;
      repeat (40) @(negedge clk);
      check("rand_emitted_some", 64'(emitted > 20), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
